muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative RV32M/RV64M multiply/divide unit for the EX stage, replacing the single-cycle multiply/divide paths of the combinational ALU. It accepts one operation through a START/BUSY/DONE handshake and computes the result over XLEN+1 cycles. Signs are handled explicitly for all eight M-extension operations. Divide-by-zero and signed-overflow cases are spec-exact and complete in one cycle. The pipeline stalls on BUSY and can cancel an in-flight operation with FLUSH.

Parameters:
XLEN, 32, operand/result width; legal values 32, 64.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-low reset.
START  input  1  request a new operation; sampled only in IDLE or DONE.
FLUSH  input  1  cancel the in-flight operation; has priority over START.
SELECT  input  3  func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
OPERAND1  input  XLEN  rs1 value (multiplicand / dividend).
OPERAND2  input  XLEN  rs2 value (multiplier / divisor).
BUSY  output  1  high in CALC and FIX.
DONE  output  1  one-cycle pulse: RESULT is valid.
RESULT  output  XLEN  final result; held until the next accepted START.

Behaviour:
- Reset (RESET=0 at an edge): state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal registers cleared. Reset overrides everything, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- Accept condition: START=1, FLUSH=0, state IDLE or DONE (back-to-back issue allowed). On accept, latch SELECT, the magnitudes of the operands, and the result sign. START in CALC/FIX is ignored.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: OPERAND1 signed, OPERAND2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Result sign:
  - Multiply: sign1 XOR sign2.
  - DIV: sign1 XOR sign2.
  - REM: sign of the dividend.
- Fast path on accept (next state DONE, latency 1 cycle):
  - Divisor==0: DIV/DIVU return all ones; REM/REMU return OPERAND1.
  - Signed overflow (DIV/REM with OPERAND1=most negative, OPERAND2=all ones): DIV returns OPERAND1; REM returns 0.
- CALC: exactly XLEN cycles; counter counts 0..XLEN-1.
  - Multiply: radix-2 shift-add into a 2*XLEN product register.
  - Divide: restoring, one quotient bit per cycle; XLEN-bit remainder plus one guard bit.
- FIX (1 cycle):
  - Apply two's-complement negation if the result is negative.
  - Select the output: MUL takes the low half; MULH/MULHSU/MULHU take the high half; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Write RESULT.
- DONE (1 cycle): DONE=1, BUSY=0. Next state is IDLE, or CALC/DONE if a new START is accepted.
- Latency: accept edge -> DONE high after XLEN+2 edges (normal) or 1 edge (fast path). Throughput is one operation per XLEN+2 cycles.
- FLUSH=1 in CALC or FIX: next state IDLE, no DONE pulse, RESULT unchanged. FLUSH in IDLE/DONE suppresses acceptance.
- DONE is never high in the same cycle as BUSY.
- RESULT changes only on the FIX edge or a fast-path edge.
- Operand inputs may change freely after acceptance.

Test Plan:
- Reset: hold RESET=0 three cycles with START=1 -> BUSY=0, DONE=0, RESULT=0; no operation accepted.
- MUL 7 x 0xFFFFFFFD -> RESULT 0xFFFFFFEB. DONE exactly 34 cycles after the accept edge. BUSY high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 7 / 0 -> 0xFFFFFFFF and REMU 7 % 0 -> 7, each with DONE one cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Both on the fast path.
- Assert FLUSH at CALC cycle 10 -> IDLE next edge, no DONE, RESULT keeps the prior value.
- Assert START during DONE -> new operation accepted with no idle gap.
- Assert START while BUSY -> ignored.
- Assert RESET mid-CALC -> all outputs cleared.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// START/BUSY/DONE handshake bundle for the iterative multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            START;
  logic            FLUSH;
  logic [2:0]      SELECT;
  logic [XLEN-1:0] OPERAND1;
  logic [XLEN-1:0] OPERAND2;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (output START, FLUSH, SELECT, OPERAND1, OPERAND2,
                  input  BUSY, DONE, RESULT);
  modport slave  (input  START, FLUSH, SELECT, OPERAND1, OPERAND2,
                  output BUSY, DONE, RESULT);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: sign-magnitude operands, XLEN-cycle
// shift-add / restoring-divide core, one fix-up cycle, one-cycle fast path.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic           CLK,
  input logic           RESET,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [XLEN-1:0]   m, lo, acc, result;
  logic              neg;
  logic [CNT_W-1:0]  cnt;

  // ---------------- issue decode ----------------
  logic            is_div, op1_signed, op2_signed, sign1, sign2, res_neg;
  logic            div_zero, div_ovf, fast, accept, last;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    is_div     = bus.SELECT[2];
    op1_signed = (bus.SELECT == 3'b000) || (bus.SELECT == 3'b001) || (bus.SELECT == 3'b010) ||
                 (bus.SELECT == 3'b100) || (bus.SELECT == 3'b110);
    op2_signed = (bus.SELECT == 3'b000) || (bus.SELECT == 3'b001) ||
                 (bus.SELECT == 3'b100) || (bus.SELECT == 3'b110);
    sign1      = op1_signed & bus.OPERAND1[XLEN-1];
    sign2      = op2_signed & bus.OPERAND2[XLEN-1];
    mag1       = sign1 ? -bus.OPERAND1 : bus.OPERAND1;
    mag2       = sign2 ? -bus.OPERAND2 : bus.OPERAND2;
    // remainder follows the dividend; everything else is the XOR of signs
    res_neg    = (is_div & bus.SELECT[1]) ? sign1 : (sign1 ^ sign2);
    div_zero   = is_div & (bus.OPERAND2 == '0);
    div_ovf    = is_div & ~bus.SELECT[0] & (bus.OPERAND1 == MIN_NEG) & (bus.OPERAND2 == '1);
    fast       = div_zero | div_ovf;
    if (div_zero) fast_res = bus.SELECT[1] ? bus.OPERAND1 : '1;
    else          fast_res = bus.SELECT[1] ? '0 : bus.OPERAND1;
    accept     = bus.START & ~bus.FLUSH & ((state == S_IDLE) || (state == S_DONE));
    last       = (cnt == CNT_W'(XLEN - 1));
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0] mul_sum, div_sh, div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc} + {1'b0, (lo[0] ? m : {XLEN{1'b0}})};
    // guard bit: the shifted partial remainder can exceed XLEN bits
    div_sh   = {acc, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, m};
  end

  // ---------------- fix-up ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = neg ? -{acc, lo} : {acc, lo};
    quo_s  = neg ? -lo  : lo;
    rem_s  = neg ? -acc : acc;
    case (op)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_s;
      default:                fix_res = rem_s;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? (fast ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:         state_nxt = bus.FLUSH ? S_IDLE : (last ? S_FIX : S_CALC);
      S_FIX:          state_nxt = bus.FLUSH ? S_IDLE : S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY   = (state == S_CALC) || (state == S_FIX);
    bus.DONE   = (state == S_DONE);
    bus.RESULT = result;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op <= '0; m <= '0; lo <= '0; acc <= '0; neg <= 1'b0; cnt <= '0; result <= '0;
    end else if (accept) begin
      op  <= bus.SELECT;
      neg <= res_neg;
      cnt <= '0;
      acc <= '0;
      // m holds the multiplicand or divisor; lo holds multiplier or dividend
      m   <= is_div ? mag2 : mag1;
      lo  <= is_div ? mag1 : mag2;
      if (fast) result <= fast_res;
    end else if (state == S_CALC && !bus.FLUSH) begin
      cnt <= cnt + 1'b1;
      if (op[2]) begin
        acc <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
        lo  <= {lo[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        acc <= mul_sum[XLEN:1];
        lo  <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end else if (state == S_FIX && !bus.FLUSH) begin
      result <= fix_res;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every DONE pulse.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.CLK(clk), .RESET(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.DONE) begin
      chk("done_busy_overlap", {63'd0, bus.BUSY}, 64'd0);
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("result", {32'd0, bus.RESULT}, {32'd0, exp_q.pop_front()});
    end
  end

  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    bus.START = 1'b1; bus.SELECT = sel; bus.OPERAND1 = a; bus.OPERAND2 = b;
    if (push) exp_q.push_back(exp);
  endtask

  // from just before the accept edge: count edges until DONE appears
  task automatic finish(input string name, input int exp_lat, input bit hold_start);
    int n, busy_n;
    bit seen;
    @(posedge clk); #1;
    bus.START = hold_start;
    bus.SELECT = 3'($urandom); bus.OPERAND1 = $urandom; bus.OPERAND2 = $urandom;
    n = 1; busy_n = 0; seen = bus.DONE;
    while (!seen && n < 100) begin
      if (bus.BUSY) busy_n++;
      if (n == 20) bus.START = 1'b0;
      @(posedge clk); #1;
      n++;
      seen = bus.DONE;
    end
    bus.START = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    if (exp_lat > 1) chk({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
  endtask

  task automatic op(input string name, input logic [2:0] sel, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clk);
    issue(sel, a, b, exp, 1'b1);
    finish(name, lat, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.FLUSH = 1'b0;
    issue(3'b000, 32'd2, 32'd3, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_busy", {63'd0, bus.BUSY}, 64'd0);
      chk("reset_done", {63'd0, bus.DONE}, 64'd0);
      chk("reset_result", {32'd0, bus.RESULT}, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1; bus.START = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", {63'd0, bus.BUSY}, 64'd0);

    op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    op("mul_lo",   3'b000, 32'h12345678, 32'h10,       32'h23456780, 34);
    op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    op("div_nd",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    op("rem_nd",   3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
    op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       34);
    op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        34);
    op("divu_z",   3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
    op("remu_z",   3'b111, 32'd7,        32'd0,        32'd7,        1);
    op("div_z",    3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
    op("rem_z",    3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
    op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // back-to-back: second START raised while the first is in DONE
    @(negedge clk);
    issue(3'b000, 32'd6, 32'd9, 32'd54, 1'b1);
    finish("b2b_first", 34, 1'b0);
    issue(3'b101, 32'd81, 32'd9, 32'd9, 1'b1);
    finish("b2b_second", 34, 1'b0);

    // START held high during CALC must not disturb the running op
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd5, 32'd15, 1'b1);
    finish("start_busy", 34, 1'b1);

    // flush at CALC cycle 10
    @(negedge clk);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0);
    @(posedge clk); #1; bus.START = 1'b0;
    repeat (10) @(posedge clk);
    #1; bus.FLUSH = 1'b1;
    @(posedge clk); #1; bus.FLUSH = 1'b0;
    chk("flush_busy", {63'd0, bus.BUSY}, 64'd0);
    chk("flush_done", {63'd0, bus.DONE}, 64'd0);
    chk("flush_result", {32'd0, bus.RESULT}, 64'd15);
    repeat (40) @(posedge clk);
    #1 chk("flush_result_hold", {32'd0, bus.RESULT}, 64'd15);

    // flush in IDLE suppresses acceptance
    @(negedge clk); bus.FLUSH = 1'b1;
    issue(3'b000, 32'd1, 32'd1, 32'd0, 1'b0);
    @(posedge clk); #1; bus.FLUSH = 1'b0; bus.START = 1'b0;
    chk("flush_idle_busy", {63'd0, bus.BUSY}, 64'd0);

    // reset mid-CALC
    op("pre_rst", 3'b000, 32'd4, 32'd4, 32'd16, 34);
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd5, 32'd0, 1'b0);
    @(posedge clk); #1; bus.START = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", {63'd0, bus.BUSY}, 64'd0);
    chk("rst_mid_done", {63'd0, bus.DONE}, 64'd0);
    chk("rst_mid_result", {32'd0, bus.RESULT}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    op("post_rst", 3'b100, 32'd20, 32'hFFFFFFFB, 32'hFFFFFFFC, 34);

    repeat (5) @(posedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
